mod2011_mul_ctrl: RTL and testbench

MOD2011_MUL_CTRL -- requirements
Module: mod2011_mul_ctrl

---
 rtl/mod2011_mul_ctrl.sv | 133 +++++++++++++
 tb/tb_mod2011_mul_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mod2011_mul_ctrl.sv
// mod2011_mul_ctrl: sequential modular multiplier, z = (a*b) mod MODULUS.
// Latency: out_valid rises W+1 cycles after the accept cycle (the RUN phase is W cycles).
//   With range checking, out-of-range operands go to DONE on the accept edge instead (1 cycle).
// Backpressure: in_ready is high only in IDLE, and the result is held in DONE until out_ready.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid/in_ready    operand handshake (a, b)
//   out_valid/out_ready  result handshake (z, err)
//   busy                 high while the shift-and-add loop runs
//
// Optional feature: define MOD2011_RANGE_CHECK_EN to flag operands >= MODULUS with err=1
// and z=0. Without the macro, such operands are reduced once at accept and err is tied low.
module mod2011_mul_ctrl #(
  parameter int W       = 11,
  parameter int MODULUS = 2011
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] z,
  output logic         err,
  output logic         busy
);

  localparam int            CW       = (W > 1) ? $clog2(W) : 1;
  localparam logic [W:0]    MOD_X    = (W+1)'(MODULUS);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [W-1:0]  a_r, b_r;
  logic [W-1:0]  acc;          // always < MODULUS, so W bits hold it
  logic [CW-1:0] cnt;
  logic          accept;
  logic          range_err;
  logic [W-1:0]  a_ld, b_ld;
  logic [W:0]    a_ext, b_ext;
  logic [W:0]    t_dbl, t_red1, t_add, t_red2;

  assign accept = in_valid & in_ready;
  assign a_ext  = {1'b0, a};
  assign b_ext  = {1'b0, b};

`ifdef MOD2011_RANGE_CHECK_EN
  logic err_r;
  assign range_err = (a_ext >= MOD_X) | (b_ext >= MOD_X);
  // Out-of-range pairs never enter RUN, so raw operands are loaded as-is.
  assign a_ld      = a;
  assign b_ld      = b;
  assign err       = err_r;
`else
  assign range_err = 1'b0;
  // A single subtraction is enough because 2^W < 2*MODULUS.
  assign a_ld      = (a_ext >= MOD_X) ? W'(a_ext - MOD_X) : a;
  assign b_ld      = (b_ext >= MOD_X) ? W'(b_ext - MOD_X) : b;
  assign err       = 1'b0;
`endif

  // One MSB-first step. Every temporary stays <= 2*MODULUS-2, which fits in W+1 bits.
  always_comb begin
    t_dbl  = {acc, 1'b0};
    t_red1 = (t_dbl >= MOD_X) ? (t_dbl - MOD_X) : t_dbl;
    t_add  = b_r[cnt] ? (t_red1 + {1'b0, a_r}) : t_red1;
    t_red2 = (t_add >= MOD_X) ? (t_add - MOD_X) : t_add;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (accept) state_nx = range_err ? DONE : RUN;
      RUN:  if (cnt == '0) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r <= '0;
      b_r <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_r <= a_ld;
            b_r <= b_ld;
            acc <= '0;
            cnt <= CNT_LAST;
          end
        end
        RUN: begin
          acc <= W'(t_red2);
          if (cnt != '0) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MOD2011_RANGE_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_r <= 1'b0;
    end else if (accept) begin
      err_r <= range_err;
    end
  end
`endif

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN);
  assign out_valid = (state == DONE);
  // acc is cleared at accept and frozen in DONE, so it doubles as the result register.
  assign z         = acc;

endmodule

// File: tb/tb_mod2011_mul_ctrl.sv
// tb_mod2011_mul_ctrl: directed and randomized checks of mod2011_mul_ctrl.
// Latency: samples are taken 1 time unit after each rising edge; the accept-edge sample is cycle 1.
// Backpressure: exercises out_ready stalls, the result hold and in_valid being ignored while busy.
module tb_mod2011_mul_ctrl;

  localparam int W = 11;
  localparam int M = 2011;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         in_ready, out_valid, err, busy;
  logic [W-1:0] z;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mod2011_mul_ctrl #(.W(W), .MODULUS(M)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .z         (z),
    .err       (err),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Offer one pair, measure latency and busy cycles, check the result, then consume it.
  task automatic run_op(input string tag, input int av, input int bv,
                        input int ez, input int eerr, input int elat);
    int n;
    int nbusy;
    a = W'(av);
    b = W'(bv);
    in_valid = 1'b1;
    check({tag, "/in_ready_before"}, 32'(in_ready), 1);
    step;
    in_valid = 1'b0;
    n = 1;
    nbusy = 0;
    check({tag, "/in_ready_after"}, 32'(in_ready), 0);
    while (!out_valid && n < 60) begin
      if (busy) nbusy++;
      step;
      n++;
    end
    check({tag, "/latency"}, 32'(n), 32'(elat));
    check({tag, "/busy_cycles"}, 32'(nbusy), 32'(elat - 1));
    check({tag, "/z"}, 32'(z), 32'(ez));
    check({tag, "/err"}, 32'(err), 32'(eerr));
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    check({tag, "/out_valid_cleared"}, 32'(out_valid), 0);
    check({tag, "/in_ready_idle"}, 32'(in_ready), 1);
  endtask

  initial begin
    int n;
    int saw;
    int av, bv, ez;
    logic [W-1:0] z_hold;

    // Reset state
    #12;
    check("rst/in_ready", 32'(in_ready), 1);
    check("rst/out_valid", 32'(out_valid), 0);
    check("rst/z", 32'(z), 0);
    check("rst/err", 32'(err), 0);
    check("rst/busy", 32'(busy), 0);
    step;
    rst_n = 1'b1;

    // First accept on the first edge with rst_n high: 1000*3 = 3000 - 2011 = 989
    run_op("first", 1000, 3, 989, 0, 12);
    run_op("max_sq", 2010, 2010, 1, 0, 12);
    run_op("zero_a", 0, 1234, 0, 0, 12);
    run_op("one_b", 2010, 1, 2010, 0, 12);
    run_op("pow2", 1024, 1024, 845, 0, 12);
    run_op("small", 1, 2010, 2010, 0, 12);

    // Out-of-range operands
`ifdef MOD2011_RANGE_CHECK_EN
    run_op("range_a", 2047, 2, 0, 1, 1);
    run_op("range_b", 5, 2040, 0, 1, 1);
`else
    run_op("range_a", 2047, 2, 72, 0, 12);
    run_op("range_b", 5, 2040, 145, 0, 12);
`endif
    run_op("after_range", 3, 4, 12, 0, 12);

    // Result hold under stall with in_valid asserted and operands toggling: (-11)^2 = 121
    a = W'(2000);
    b = W'(2000);
    in_valid = 1'b1;
    out_ready = 1'b1;
    step;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 60) begin
      step;
      n++;
    end
    check("hold/latency", 32'(n), 12);
    z_hold = z;
    check("hold/z", 32'(z_hold), 121);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      out_ready = 1'b0;
      a = W'($urandom_range(0, 2047));
      b = W'($urandom_range(0, 2047));
      step;
      check("hold/z_stable", 32'(z), 121);
      check("hold/out_valid", 32'(out_valid), 1);
      check("hold/in_ready", 32'(in_ready), 0);
    end
    a = W'(5);
    b = W'(6);
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
    check("hold/idle_in_ready", 32'(in_ready), 1);
    check("hold/idle_out_valid", 32'(out_valid), 0);
    check("hold/idle_busy", 32'(busy), 0);
    step;
    in_valid = 1'b0;
    check("hold/next_accept_busy", 32'(busy), 1);
    n = 1;
    while (!out_valid && n < 60) begin
      step;
      n++;
    end
    check("hold/next_latency", 32'(n), 12);
    check("hold/next_z", 32'(z), 30);
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;

    // Reset in the middle of RUN discards the operation
    a = W'(1000);
    b = W'(3);
    in_valid = 1'b1;
    step;
    in_valid = 1'b0;
    repeat (4) step;
    check("mid_rst/busy_before", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst/busy", 32'(busy), 0);
    check("mid_rst/out_valid", 32'(out_valid), 0);
    check("mid_rst/z", 32'(z), 0);
    step;
    rst_n = 1'b1;
    out_ready = 1'b1;
    saw = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) saw = 1;
      step;
    end
    out_ready = 1'b0;
    check("mid_rst/no_result", 32'(saw), 0);
    run_op("post_rst", 7, 9, 63, 0, 12);

    // Random in-range pairs with random out_ready, also toggled outside DONE
    for (int i = 0; i < 400; i++) begin
      av = $urandom_range(0, M - 1);
      bv = $urandom_range(0, M - 1);
      ez = int'((longint'(av) * longint'(bv)) % longint'(M));
      a = W'(av);
      b = W'(bv);
      in_valid = 1'b1;
      n = 0;
      while (!in_ready && n < 60) begin
        step;
        n++;
      end
      step;
      in_valid = 1'b0;
      n = 0;
      saw = 0;
      while (n < 200 && saw == 0) begin
        out_ready = 1'($urandom_range(0, 1));
        if (out_valid && out_ready) begin
          check("rand/z", 32'(z), 32'(ez));
          saw = 1;
        end
        step;
        n++;
      end
      out_ready = 1'b0;
      if (saw == 0) check("rand/timeout", 32'(saw), 1);
      if ((i % 50) == 0) check("rand/no_dup", 32'(out_valid), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
